pattern_response_capture: RTL and testbench
===========================================

PATTERN_RESPONSE_CAPTURE -- requirements
Module: pattern_response_capture

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, meaning the number of whole clock cycles waited after a new vector is driven before the response is sampled (legal range 1..15).
REQ-002 SHALL have port CK  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  level-sampled request to begin one exhaustive sweep.
REQ-005 SHALL have port N  output  5  registered stimulus vector driven to the device under test.
REQ-006 SHALL have port resp_in  input  1  response bit from the device under test.
REQ-007 SHALL have port golden  input  32  expected truth table; bit k is the expected response for vector k; sampled only in SAMPLE.
REQ-008 SHALL have port rec_valid  output  1  record available.
REQ-009 SHALL have port rec_ready  input  1  consumer accepts the record.
REQ-010 SHALL have port rec_vec  output  5  vector of the current record.
REQ-011 SHALL have port rec_bit  output  1  sampled response of the current record.
REQ-012 SHALL have port rec_miss  output  1  1 when rec_bit differs from golden[rec_vec].
REQ-013 SHALL have port table_out  output  32  captured truth table; bit k holds the response for vector k.
REQ-014 SHALL have port mismatch_cnt  output  6  count of mismatching vectors in the current sweep (0..32).
REQ-015 SHALL have port busy  output  1  sweep in progress.
REQ-016 SHALL have port done  output  1  sweep complete; held until the next sweep starts.

Function
REQ-017 The FSM SHALL use the states IDLE, APPLY, SETTLE, SAMPLE, EMIT and DONE.
REQ-018 In IDLE or DONE, start=1 SHALL clear idx, table_out and mismatch_cnt, clear done, and enter APPLY on the next edge.
REQ-019 APPLY SHALL register N=idx, load the settle counter with SETTLE_CYCLES, and move to SETTLE.
REQ-020 SETTLE SHALL decrement the counter each cycle and move to SAMPLE after exactly SETTLE_CYCLES cycles.
REQ-021 SAMPLE SHALL perform all of the following on one edge: write resp_in into table_out[idx], set rec_vec=idx, set rec_bit=resp_in, set rec_miss=resp_in XOR golden[idx], increment mismatch_cnt if rec_miss, assert rec_valid, and move to EMIT.
REQ-022 In EMIT, rec_valid and all record fields SHALL stay stable until rec_ready=1; backpressure of any length is legal.
REQ-023 On the EMIT handshake edge, rec_valid SHALL drop; if idx==31 the FSM SHALL enter DONE, otherwise idx+1 SHALL be applied and the FSM SHALL enter APPLY.
REQ-024 With rec_ready held at 1, each vector SHALL take SETTLE_CYCLES+3 cycles, and the full sweep SHALL take 32*(SETTLE_CYCLES+3) cycles from start to done.
REQ-025 idx SHALL be 5 bits and SHALL never wrap; 31 is the terminal value.
REQ-026 busy SHALL be 1 in APPLY, SETTLE, SAMPLE and EMIT, and 0 otherwise.
REQ-027 done SHALL rise on entry to DONE.
REQ-028 start SHALL be ignored while busy=1.
REQ-029 N SHALL hold its last value in DONE and SHALL change only in APPLY.
REQ-030 mismatch_cnt SHALL saturate at 32; it cannot exceed 32 by construction.
REQ-031 golden changing mid-sweep SHALL affect only vectors sampled after the change.
REQ-032 rec_valid SHALL never assert outside EMIT.

Reset
REQ-033 reset=1 SHALL force IDLE immediately, independent of CK, at any time including mid-sweep or mid-handshake.
REQ-034 Reset values SHALL be: N=0, idx=0, rec_valid=0, rec_vec=0, rec_bit=0, rec_miss=0, table_out=0, mismatch_cnt=0, busy=0, done=0.
REQ-035 After reset is released, the block SHALL wait in IDLE for start; a pending record SHALL be discarded.

Verification
REQ-036 Scenario 1: resp_in=N[0], golden=32'hAAAAAAAA, rec_ready=1, SETTLE_CYCLES=1 -> table_out=32'hAAAAAAAA, mismatch_cnt=0, done after 128 cycles, 32 records with rec_vec 0..31 in order.
REQ-037 Scenario 2: resp_in=AND of all N bits, golden=0 -> exactly one record with rec_miss=1 (rec_vec=31), mismatch_cnt=1, table_out=32'h80000000.
REQ-038 Scenario 3: rec_ready held 0 for 7 cycles on vector 5 -> rec_valid and record fields stable for those cycles, N stays 5, no sample lost, final table_out correct.
REQ-039 Scenario 4: reset pulsed at vector 17 while in EMIT -> all outputs at reset values asynchronously; a new start produces a clean sweep beginning at N=0.
REQ-040 Scenario 5: start pulsed repeatedly during the sweep -> no restart, sweep completes normally; start in DONE -> table_out and mismatch_cnt cleared, done=0, new sweep begins.
REQ-041 Scenario 6: SETTLE_CYCLES=4 with resp_in = N[4] delayed 3 cycles -> table_out=32'hFFFF0000, mismatch_cnt=0 against golden=32'hFFFF0000.

Source files
------------

// File: rtl/pattern_response_capture.sv
// Exhaustive 5-input sweep: drives each vector, waits, samples the
// response, and hands every sample out as a valid/ready record.
module pattern_response_capture #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        CK,
  input  logic        reset,
  input  logic        start,
  output logic [4:0]  N,
  input  logic        resp_in,
  input  logic [31:0] golden,
  output logic        rec_valid,
  input  logic        rec_ready,
  output logic [4:0]  rec_vec,
  output logic        rec_bit,
  output logic        rec_miss,
  output logic [31:0] table_out,
  output logic [5:0]  mismatch_cnt,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    SAMPLE,
    EMIT,
    DONE
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  state_t     state;
  logic [4:0] idx;
  logic [3:0] cnt;
  logic       miss;

  assign miss = resp_in ^ golden[idx];

  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      cnt          <= '0;
      N            <= '0;
      rec_valid    <= 1'b0;
      rec_vec      <= '0;
      rec_bit      <= 1'b0;
      rec_miss     <= 1'b0;
      table_out    <= '0;
      mismatch_cnt <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            idx          <= '0;
            table_out    <= '0;
            mismatch_cnt <= '0;
            done         <= 1'b0;
            busy         <= 1'b1;
            state        <= APPLY;
          end
        end
        APPLY: begin
          N     <= idx;
          cnt   <= SETTLE_LOAD;
          state <= SETTLE;
        end
        SETTLE: begin
          cnt <= cnt - 4'd1;
          // leave after exactly SETTLE_CYCLES cycles here
          if (cnt <= 4'd1) state <= SAMPLE;
        end
        SAMPLE: begin
          table_out[idx] <= resp_in;
          rec_vec        <= idx;
          rec_bit        <= resp_in;
          rec_miss       <= miss;
          if (miss && mismatch_cnt < 6'd32)
            mismatch_cnt <= mismatch_cnt + 6'd1;
          rec_valid      <= 1'b1;
          state          <= EMIT;
        end
        EMIT: begin
          if (rec_ready) begin
            rec_valid <= 1'b0;
            if (idx == 5'd31) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx   <= idx + 5'd1;
              state <= APPLY;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_response_capture.sv
// Bench for pattern_response_capture: table of full sweeps with a
// record scoreboard, plus reset-abort and long-settle sequences.
module tb_pattern_response_capture;

  logic        CK = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  N;
  logic        resp_in;
  logic [31:0] golden;
  logic        rec_valid;
  logic        rec_ready;
  logic [4:0]  rec_vec;
  logic        rec_bit;
  logic        rec_miss;
  logic [31:0] table_out;
  logic [5:0]  mismatch_cnt;
  logic        busy;
  logic        done;

  logic        start4;
  logic [4:0]  N4;
  logic        resp4;
  logic        rec_valid4;
  logic        rec_ready4;
  logic [4:0]  rec_vec4;
  logic        rec_bit4;
  logic        rec_miss4;
  logic [31:0] table4;
  logic [5:0]  mis4;
  logic        busy4;
  logic        done4;
  logic [2:0]  dly;

  int errors = 0;
  int checks = 0;
  int cur_mode = 0;

  typedef struct packed {
    logic [4:0] vec;
    logic       bt;
    logic       miss;
  } rec_t;
  rec_t sb[$];

  typedef struct {
    int          mode;
    logic [31:0] gold;
    logic [31:0] exp_tab;
    int          exp_mis;
    int          stall_vec;
    int          abort_vec;
    bit          pulses;
  } vec_t;
  vec_t tbl[6];

  always #5 CK = ~CK;

  pattern_response_capture #(.SETTLE_CYCLES(1)) dut (
    .CK(CK), .reset(reset), .start(start), .N(N),
    .resp_in(resp_in), .golden(golden),
    .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_vec(rec_vec), .rec_bit(rec_bit), .rec_miss(rec_miss),
    .table_out(table_out), .mismatch_cnt(mismatch_cnt),
    .busy(busy), .done(done)
  );

  pattern_response_capture #(.SETTLE_CYCLES(4)) dut4 (
    .CK(CK), .reset(reset), .start(start4), .N(N4),
    .resp_in(resp4), .golden(32'hFFFF0000),
    .rec_valid(rec_valid4), .rec_ready(rec_ready4),
    .rec_vec(rec_vec4), .rec_bit(rec_bit4), .rec_miss(rec_miss4),
    .table_out(table4), .mismatch_cnt(mis4),
    .busy(busy4), .done(done4)
  );

  function automatic logic resp_f(int mode, logic [4:0] n);
    case (mode)
      0: return n[0];
      1: return &n;
      2: return n[2] ^ n[4];
      default: return ~n[1];
    endcase
  endfunction

  always_comb resp_in = resp_f(cur_mode, N);

  // device with a 3-cycle response path
  always @(posedge CK or posedge reset)
    if (reset) dly <= '0;
    else dly <= {dly[1:0], N4[4]};
  assign resp4 = dly[2];

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // records are compared on the handshake edge that follows
  always @(negedge CK) begin
    if (rec_valid && rec_ready && !reset) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        rec_t e;
        e = sb.pop_front();
        check("rec_vec", rec_vec, e.vec);
        check("rec_bit", rec_bit, e.bt);
        check("rec_miss", rec_miss, e.miss);
      end
    end
  end

  task automatic check_reset();
    check("rst_N", N, 0);
    check("rst_valid", rec_valid, 0);
    check("rst_vec", rec_vec, 0);
    check("rst_bit", rec_bit, 0);
    check("rst_miss", rec_miss, 0);
    check("rst_table", table_out, 0);
    check("rst_mis", mismatch_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
  endtask

  task automatic run_sweep(input vec_t t);
    int cycles;
    int stalls;
    logic eb;
    cur_mode = t.mode;
    golden = t.gold;
    sb.delete();
    for (int v = 0; v < 32; v++) begin
      rec_t r;
      r.vec = 5'(v);
      r.bt = resp_f(t.mode, 5'(v));
      r.miss = r.bt ^ t.gold[v];
      sb.push_back(r);
    end
    rec_ready = 1'b1;
    start = 1'b1;
    @(posedge CK); #1;
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_done", done, 0);
    check("start_table", table_out, 0);
    check("start_mis", mismatch_cnt, 0);
    cycles = 0;
    stalls = 0;
    while (!done && cycles < 2000) begin
      if (rec_valid && t.abort_vec >= 0 &&
          int'(rec_vec) == t.abort_vec) begin
        rec_ready = 1'b0;
        #2 reset = 1'b1;
        #1 check_reset();
        @(posedge CK); #1;
        reset = 1'b0;
        sb.delete();
        rec_ready = 1'b1;
        repeat (3) @(posedge CK);
        #1;
        check("post_rst_busy", busy, 0);
        check("post_rst_valid", rec_valid, 0);
        return;
      end
      if (rec_valid && int'(rec_vec) == t.stall_vec &&
          stalls < 7) begin
        eb = resp_f(t.mode, rec_vec);
        check("stall_N", N, 5'(t.stall_vec));
        check("stall_bit", rec_bit, eb);
        check("stall_miss", rec_miss, eb ^ t.gold[t.stall_vec]);
        rec_ready = 1'b0;
        stalls++;
      end else begin
        rec_ready = 1'b1;
      end
      if (t.pulses) start = (cycles % 5 == 2);
      @(posedge CK); #1;
      cycles++;
    end
    start = 1'b0;
    check("sweep_timeout", done, 1);
    check("sweep_cycles", cycles,
          128 + (t.stall_vec >= 0 ? 7 : 0));
    check("table_out", table_out, t.exp_tab);
    check("mismatch_cnt", mismatch_cnt, t.exp_mis);
    check("done_busy", busy, 0);
    check("done_N", N, 31);
    check("sb_left", sb.size(), 0);
  endtask

  initial begin
    int cycles;
    tbl[0] = '{0, 32'hAAAAAAAA, 32'hAAAAAAAA, 0, -1, -1, 0};
    tbl[1] = '{1, 32'h00000000, 32'h80000000, 1, -1, -1, 0};
    tbl[2] = '{2, 32'h00000000, 32'h0F0FF0F0, 16, -1, -1, 0};
    tbl[3] = '{3, 32'hCCCCCCCC, 32'h33333333, 32, -1, -1, 0};
    tbl[4] = '{0, 32'hAAAAAAAA, 32'hAAAAAAAA, 0, 5, -1, 0};
    tbl[5] = '{2, 32'h0F0FF0F0, 32'h0F0FF0F0, 0, -1, -1, 1};
    reset = 1'b1;
    start = 1'b0;
    start4 = 1'b0;
    rec_ready = 1'b1;
    rec_ready4 = 1'b1;
    golden = '0;
    #3 check_reset();
    @(posedge CK); #1;
    reset = 1'b0;
    repeat (2) @(posedge CK);
    #1;
    check("idle_busy", busy, 0);

    for (int i = 0; i < 6; i++) run_sweep(tbl[i]);

    run_sweep('{1, 32'h0, 32'h0, 0, -1, 17, 0});
    run_sweep(tbl[1]);

    start4 = 1'b1;
    @(posedge CK); #1;
    start4 = 1'b0;
    cycles = 0;
    while (!done4 && cycles < 2000) begin
      @(posedge CK); #1;
      cycles++;
    end
    check("s4_done", done4, 1);
    check("s4_cycles", cycles, 224);
    check("s4_table", table4, 32'hFFFF0000);
    check("s4_mis", mis4, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
